// File: rtl/bus_pkg.sv
// bus_pkg: shared types and helpers for the bus master multiplexer.
//   state_e     - ownership FSM states (IDLE / XFER / RELEASE)
//   LEN_W       - width of a burst-length field (beats minus one)
//   onehot2idx  - index of the lowest set bit of a vector (up to 32 bits)
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int LEN_W      = 4;
  localparam int MAX_ONEHOT = 32;

  // Scans from the top down so the last hit wins, leaving the lowest set
  // bit; a multi-hot grant therefore resolves to the lowest master index.
  function automatic logic [4:0] onehot2idx(input logic [MAX_ONEHOT-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_ONEHOT - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_onehot_enc.sv
// bus_onehot_enc: one-hot (or multi-hot) vector to index encoder.
//   onehot in  N          - input vector, N <= 32
//   idx    out $clog2(N)  - index of the lowest set bit (0 when none set)
//   any    out 1          - at least one bit set
module bus_onehot_enc
  import bus_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  assign idx = IDX_W'(onehot2idx(MAX_ONEHOT'(onehot)));
  assign any = |onehot;

endmodule

// File: rtl/bus_master_mux.sv
// bus_master_mux: latches the arbiter's grant as bus owner, holds ownership
// for a whole burst, routes the owner's request channel to the shared slave
// port and returns registered read data to the owner.
//
// Ports:
//   clk, reset_n        - clock (rising edge), async active-low reset
//   grant               - one-hot grant from the arbiter (lowest bit wins)
//   m_valid/m_addr/m_wdata/m_we/m_len - per-master request channels (packed)
//   m_ready             - beat accepted, owner bit only
//   m_rdata, m_rvalid   - registered read data and per-master valid pulse
//   s_valid/s_addr/s_wdata/s_we, s_ready, s_rdata - shared slave port
//   bus_busy            - high in every state except IDLE
//   owner               - current/last owner index
//   err                 - stall watchdog pulse
//
// Optional feature: define BUS_MUX_TIMEOUT_EN to enable the stall watchdog
// (TIMEOUT_CYCLES consecutive stalled XFER cycles abort the burst).
module bus_master_mux
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS-1:0]            grant,
  input  logic [NUM_MASTERS-1:0]            m_valid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*LEN_W-1:0]      m_len,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic                              s_valid,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic                              s_we,
  input  logic                              s_ready,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  output logic                              bus_busy,
  output logic [$clog2(NUM_MASTERS)-1:0]    owner,
  output logic                              err
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  state_e           state, state_nxt;
  logic [LEN_W-1:0] beat_cnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             hs;
  logic             abort;

  bus_onehot_enc #(.N(NUM_MASTERS)) u_grant_enc (
    .onehot (grant),
    .idx    (gnt_idx),
    .any    (gnt_any)
  );

`ifdef BUS_MUX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and slave-side routing. Slave outputs are zero outside XFER so
  // an asynchronous reset drops s_valid without waiting for an edge.
  always_comb begin
    state_nxt = state;
    s_valid   = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_we      = 1'b0;
    m_ready   = '0;
    hs        = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) state_nxt = XFER;
      end
      XFER: begin
        s_valid = m_valid[owner];
        s_addr  = m_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
        s_wdata = m_wdata[owner*DATA_WIDTH +: DATA_WIDTH];
        s_we    = m_we[owner];
        hs      = m_valid[owner] && s_ready;
`ifdef BUS_MUX_TIMEOUT_EN
        // The abort cycle is itself the last counted stall.
        abort   = !hs && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif
        if (!abort) m_ready[owner] = s_ready;
        if (abort || (hs && beat_cnt == '0)) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ownership latch, beat counter and read return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner    <= '0;
      beat_cnt <= '0;
      m_rdata  <= '0;
      m_rvalid <= '0;
    end else begin
      m_rvalid <= '0;
      if (state == IDLE && gnt_any) begin
        owner    <= gnt_idx;
        beat_cnt <= m_len[gnt_idx*LEN_W +: LEN_W];
      end
      if (hs) begin
        if (beat_cnt != '0) beat_cnt <= beat_cnt - 1'b1;
        if (!m_we[owner]) begin
          m_rdata         <= s_rdata;
          m_rvalid[owner] <= 1'b1;
        end
      end
    end
  end

`ifdef BUS_MUX_TIMEOUT_EN
  // Consecutive stalled XFER cycles; any handshake or leaving XFER clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           wd_cnt <= '0;
    else if (state == XFER && !hs && !abort) wd_cnt <= wd_cnt + 1'b1;
    else                                    wd_cnt <= '0;
  end
`endif

  assign bus_busy = (state != IDLE);
  assign err      = abort;

endmodule

// File: doc/bus_master_mux.md
# bus_master_mux

Downstream companion to the round-robin bus arbiter. It consumes the arbiter's one-hot `grant`, latches the winning master as bus owner, and holds that ownership for a whole burst even if `grant` changes. While it owns the bus, it routes the owner's request channel onto the single shared slave port and returns read data to that owner. It reports `bus_busy` so the system can suppress re-arbitration while a burst is in flight.

## Interface
- `NUM_MASTERS`, 4, number of masters, ≥2
- `DATA_WIDTH`, 32, data beat width
- `ADDR_WIDTH`, 32, address width
- `TIMEOUT_CYCLES`, 64, stall limit for the watchdog (used only when `BUS_MUX_TIMEOUT_EN` is defined)
- `clk` in 1, single clock, rising edge
- `reset_n` in 1, asynchronous, active-low reset
- `grant` in NUM_MASTERS, one-hot grant from the arbiter
- `m_valid` in NUM_MASTERS, master i presents a beat
- `m_addr` in NUM_MASTERS*ADDR_WIDTH, packed; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `m_wdata` in NUM_MASTERS*DATA_WIDTH, packed the same way
- `m_we` in NUM_MASTERS, 1 = write beat, 0 = read beat
- `m_len` in NUM_MASTERS*4, burst length minus 1 (1..16 beats), sampled at ownership
- `m_ready` out NUM_MASTERS, beat accepted
- `m_rdata` out DATA_WIDTH, registered read data
- `m_rvalid` out NUM_MASTERS, read data valid for master i
- `s_valid` out 1, `s_addr` out ADDR_WIDTH, `s_wdata` out DATA_WIDTH, `s_we` out 1: shared slave request
- `s_ready` in 1, slave accepts beat
- `s_rdata` in DATA_WIDTH, read data, valid in the handshake cycle of a read beat
- `bus_busy` out 1, high in every state except IDLE
- `owner` out $clog2(NUM_MASTERS), current/last owner index
- `err` out 1, timeout pulse

## Operation
- FSM states: IDLE, XFER, RELEASE.
- **IDLE**
  - If `grant` is non-zero, latch `owner` as the index of the lowest set bit. Multi-hot input resolves to the lowest index.
  - In the same edge, load `beat_cnt` from `m_len[owner]` and go to XFER.
  - If `grant` is zero, stay in IDLE.
- **XFER**
  - Slave outputs are driven combinationally from the owner's inputs: `s_valid` = `m_valid[owner]`, plus `s_addr`, `s_wdata` and `s_we` from that master.
  - `m_ready[owner]` = `s_ready`; every other bit of `m_ready` is 0.
  - A handshake is `s_valid && s_ready`. On each handshake, `beat_cnt` decrements.
  - A handshake with `beat_cnt` == 0 ends the burst: go to RELEASE.
  - `grant` is ignored while in XFER.
- **RELEASE**
  - Exactly one cycle: `s_valid` = 0, `bus_busy` = 1. Then go to IDLE.
  - This gives the arbiter one cycle to observe the burst end.
- **Read return:** on a read-beat handshake, register `s_rdata` into `m_rdata` and pulse `m_rvalid[owner]` on the following cycle.
- **Idle outputs:** in IDLE and RELEASE, `s_valid`, `s_we`, `m_ready` and `m_rvalid` are 0 (except a read pulse that is still due from the final beat). `s_addr` and `s_wdata` are 0.
- **Reset values:** state IDLE, `owner` 0, `beat_cnt` 0, `m_rdata` 0, `m_rvalid` 0, `bus_busy` 0, `err` 0, all slave outputs 0.
- **Reset mid-burst:** assertion forces the above immediately, without waiting for a clock edge. The burst is abandoned.
- `owner` holds its last value through RELEASE and IDLE until the next grant.

## Timing
- Grant seen at edge N → owner's `s_valid` can assert in the cycle after edge N.
- Beat throughput: 1 beat/cycle with `s_ready` held high.
- Read data latency: 1 cycle from the handshake to `m_rvalid`.
- Minimum gap between bursts: RELEASE (1 cycle) plus IDLE sampling (1 cycle).
- An L-beat burst with no stalls occupies L XFER cycles, 1 RELEASE cycle, then IDLE.
- `m_valid` deasserting mid-burst stalls the burst without ending it.

## Configuration
- `BUS_MUX_TIMEOUT_EN` defined:
  - A watchdog counts consecutive XFER cycles without a handshake and clears on every handshake.
  - When the count reaches `TIMEOUT_CYCLES`, pulse `err` for 1 cycle, force RELEASE and abandon the remaining beats.
  - No `m_ready` is issued in the abort cycle.
- `BUS_MUX_TIMEOUT_EN` undefined: no counter, `err` tied to 0, and XFER may stall indefinitely.

## Structure
- Package `bus_pkg` holds:
  - the state enum (IDLE/XFER/RELEASE);
  - `LEN_W` = 4;
  - a function that converts one-hot to index (lowest set bit).
- Sub-module `bus_onehot_enc` (one-hot → index plus any-bit flag), instantiated once on `grant`.
- Muxing, FSM, beat counter and watchdog are inline in `bus_master_mux`.

## Test plan
- **Single write:** `grant`=4'b0100, master 2 `m_len`=0, `m_we`=1, `m_addr`=0x100, `s_ready`=1 → one cycle with `s_valid`=1 and `s_addr`=0x100. Then RELEASE with `bus_busy`=1, then IDLE with `bus_busy`=0.
- **Burst under grant change:** master 1 `m_len`=3, `grant` moves to 4'b1000 mid-burst → exactly 4 handshakes, all with `owner`=1. Master 3 is granted only after RELEASE.
- **Read return:** master 0 read beat, `s_rdata`=0xDEADBEEF → the next cycle has `m_rdata`=0xDEADBEEF and `m_rvalid`=4'b0001.
- **Stalls and multi-hot grant:** `s_ready` low for 5 cycles mid-burst → `beat_cnt` holds and the burst resumes correctly. Multi-hot `grant`=4'b0110 → `owner`=1.
- **Async reset mid-burst:** drop `reset_n` between edges during beat 2 of 4 → `s_valid` falls before the next edge. After release, state is IDLE and `owner`=0.
- **Watchdog (`BUS_MUX_TIMEOUT_EN`):** `s_ready` held low, `TIMEOUT_CYCLES`=8 → `err` pulses on the 8th stalled cycle, then RELEASE and IDLE. Without the macro, the stall persists and `err` stays 0.
